fwd_scoreboard: RTL and testbench

Parametrised operand-forwarding and hazard unit for the EX stage, generalising the two-stage forwarding select to NUM_RS read ports and NUM_FWD_STAGES bypass stages. It adds a per-register pending scoreboard for long-latency writers (divider, cache-miss loads) that complete out of the pipeline on a completion bus. It produces per-port forward selects, a single hazard stall, and scoreboard occupancy and error status. It sits beside the ID/EX register and drives the EX operand muxes and the pipeline stall/bubble controls.

---
 rtl/fwd_scoreboard.sv | 105 ++++++++++
 tb/tb_fwd_scoreboard.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - EX-stage operand forwarding, hazard stall and long-latency pending scoreboard
module fwd_scoreboard #(
    parameter int NUM_RS          = 2,
    parameter int NUM_FWD_STAGES  = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int SELW            = $clog2(NUM_FWD_STAGES + 2),
    parameter int CNTW            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_RS*REG_ADDR_WIDTH-1:0]         rs_addr,
    input  logic [NUM_RS-1:0]                        rs_used,
    input  logic [NUM_FWD_STAGES*REG_ADDR_WIDTH-1:0] stg_rd_addr,
    input  logic [NUM_FWD_STAGES-1:0]                stg_reg_wr,
    input  logic [NUM_FWD_STAGES-1:0]                stg_data_rdy,
    input  logic [REG_ADDR_WIDTH-1:0]                ex_rd_addr,
    input  logic                                     ex_reg_wr,
    input  logic                                     ex_long,
    input  logic                                     cmpl_valid,
    input  logic [REG_ADDR_WIDTH-1:0]                cmpl_rd,
    output logic [NUM_RS*SELW-1:0]                   fwd_sel,
    output logic                                     hazard_stall,
    output logic [CNTW-1:0]                          pending_cnt,
    output logic                                     sb_err
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [NUM_RS-1:0]   port_stall;
    logic                waw_stall;
    logic                full_stall;
    logic                valid_cmpl;
    logic                bad_cmpl;
    logic                issue_en;

    always_comb begin
        fwd_sel    = '0;
        port_stall = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            logic [REG_ADDR_WIDTH-1:0] addr_i;
            logic                      found;
            addr_i = rs_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            found  = 1'b0;
            if (rs_used[i] && addr_i != '0) begin
                // Nearest stage wins; a not-yet-ready match must not fall through to an older copy
                for (int k = 0; k < NUM_FWD_STAGES; k++) begin
                    if (!found && stg_reg_wr[k] &&
                        stg_rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr_i) begin
                        found = 1'b1;
                        if (stg_data_rdy[k])
                            fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
                        else
                            port_stall[i] = 1'b1;
                    end
                end
                if (!found && pending[addr_i]) begin
                    if (cmpl_valid && cmpl_rd == addr_i)
                        fwd_sel[i*SELW +: SELW] = SELW'(NUM_FWD_STAGES + 1);
                    else
                        port_stall[i] = 1'b1;
                end
            end
        end
    end

    assign valid_cmpl = cmpl_valid && (cmpl_rd != '0) && pending[cmpl_rd];
    assign bad_cmpl   = cmpl_valid && !valid_cmpl;

    assign waw_stall  = ex_reg_wr && (ex_rd_addr != '0) && pending[ex_rd_addr] &&
                        !(cmpl_valid && cmpl_rd == ex_rd_addr);
    assign full_stall = ex_long && (pending_cnt == CNTW'(MAX_OUTSTANDING)) && !cmpl_valid;

    assign hazard_stall = (|port_stall) || waw_stall || full_stall;
    assign issue_en     = ex_long && ex_reg_wr && (ex_rd_addr != '0) && !hazard_stall;

    // Issue is applied after completion so a same-register overlap leaves the new write pending
    always_comb begin
        pending_nxt = pending;
        if (valid_cmpl)
            pending_nxt[cmpl_rd] = 1'b0;
        if (issue_en)
            pending_nxt[ex_rd_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
            sb_err      <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (issue_en && !valid_cmpl && pending_cnt != CNTW'(MAX_OUTSTANDING))
                pending_cnt <= pending_cnt + 1'b1;
            else if (valid_cmpl && !issue_en && pending_cnt != '0)
                pending_cnt <= pending_cnt - 1'b1;
            if (bad_cmpl)
                sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed checks of forwarding priority, load-use, scoreboard and reset
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_used;
    logic [9:0]  stg_rd_addr;
    logic [1:0]  stg_reg_wr;
    logic [1:0]  stg_data_rdy;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_wr;
    logic        ex_long;
    logic        cmpl_valid;
    logic [4:0]  cmpl_rd;
    logic [3:0]  fwd_sel;
    logic        hazard_stall;
    logic [2:0]  pending_cnt;
    logic        sb_err;

    int vectors = 0;
    int miscompares = 0;

    fwd_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_used(rs_used),
        .stg_rd_addr(stg_rd_addr), .stg_reg_wr(stg_reg_wr), .stg_data_rdy(stg_data_rdy),
        .ex_rd_addr(ex_rd_addr), .ex_reg_wr(ex_reg_wr), .ex_long(ex_long),
        .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
        .fwd_sel(fwd_sel), .hazard_stall(hazard_stall),
        .pending_cnt(pending_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        rs_addr = '0; rs_used = '0; stg_rd_addr = '0; stg_reg_wr = '0; stg_data_rdy = '0;
        ex_rd_addr = '0; ex_reg_wr = 0; ex_long = 0; cmpl_valid = 0; cmpl_rd = '0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        @(negedge clk); idle_inputs();
        ex_long = 1; ex_reg_wr = 1; ex_rd_addr = rd;
    endtask

    task automatic complete(input logic [4:0] rd);
        @(negedge clk); idle_inputs();
        cmpl_valid = 1; cmpl_rd = rd;
    endtask

    task automatic test_reset();
        idle_inputs(); rst_n = 0;
        @(negedge clk); #1;
        vectors++; if (fwd_sel !== 4'h0) begin miscompares++; $display("FAIL reset_fwd_sel got %h exp 0", fwd_sel); end
        vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", hazard_stall); end
        vectors++; if (pending_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", pending_cnt); end
        vectors++; if (sb_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", sb_err); end
        rst_n = 1;
    endtask

    task automatic test_priority();
        @(negedge clk); idle_inputs();
        rs_used = 2'b01; rs_addr = {5'd0, 5'd5};
        stg_rd_addr = {5'd5, 5'd5}; stg_reg_wr = 2'b11; stg_data_rdy = 2'b11;
        #1;
        vectors++; if (fwd_sel !== 4'h1) begin miscompares++; $display("FAIL prio_both got %h exp 1", fwd_sel); end
        stg_reg_wr = 2'b10; #1;
        vectors++; if (fwd_sel !== 4'h2) begin miscompares++; $display("FAIL prio_stage1 got %h exp 2", fwd_sel); end
        rs_addr = '0; stg_rd_addr = '0; stg_reg_wr = 2'b11; #1;
        vectors++; if (fwd_sel !== 4'h0) begin miscompares++; $display("FAIL prio_x0 got %h exp 0", fwd_sel); end
        vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL prio_x0_stall got %b exp 0", hazard_stall); end
    endtask

    task automatic test_load_use();
        @(negedge clk); idle_inputs();
        rs_used = 2'b10; rs_addr = {5'd7, 5'd0};
        stg_rd_addr = {5'd0, 5'd7}; stg_reg_wr = 2'b01; stg_data_rdy = 2'b00;
        #1;
        vectors++; if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %b exp 1", hazard_stall); end
        vectors++; if (fwd_sel !== 4'h0) begin miscompares++; $display("FAIL lu_sel got %h exp 0", fwd_sel); end
        @(negedge clk);
        stg_rd_addr = {5'd7, 5'd0}; stg_reg_wr = 2'b10; stg_data_rdy = 2'b10;
        #1;
        vectors++; if (fwd_sel !== 4'h8) begin miscompares++; $display("FAIL lu_fwd got %h exp 8", fwd_sel); end
        vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL lu_nostall got %b exp 0", hazard_stall); end
    endtask

    task automatic test_long_op();
        issue_long(5'd9); #1;
        vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL long_issue_stall got %b exp 0", hazard_stall); end
        @(negedge clk); idle_inputs();
        rs_used = 2'b01; rs_addr = {5'd0, 5'd9}; #1;
        vectors++; if (pending_cnt !== 3'd1) begin miscompares++; $display("FAIL long_cnt got %0d exp 1", pending_cnt); end
        vectors++; if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL long_read_stall got %b exp 1", hazard_stall); end
        cmpl_valid = 1; cmpl_rd = 5'd9; #1;
        vectors++; if (fwd_sel !== 4'h3) begin miscompares++; $display("FAIL long_bypass got %h exp 3", fwd_sel); end
        vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL long_bypass_stall got %b exp 0", hazard_stall); end
        @(negedge clk); idle_inputs(); #1;
        vectors++; if (pending_cnt !== 3'd0) begin miscompares++; $display("FAIL long_cnt_after got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_full_waw();
        for (int r = 1; r <= 4; r++) issue_long(5'(r));
        issue_long(5'd5); #1;
        vectors++; if (pending_cnt !== 3'd4) begin miscompares++; $display("FAIL full_cnt got %0d exp 4", pending_cnt); end
        vectors++; if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL full_stall got %b exp 1", hazard_stall); end
        cmpl_valid = 1; cmpl_rd = 5'd1; #1;
        vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL full_accept got %b exp 0", hazard_stall); end
        @(negedge clk); idle_inputs();
        ex_reg_wr = 1; ex_rd_addr = 5'd2; #1;
        vectors++; if (pending_cnt !== 3'd4) begin miscompares++; $display("FAIL full_cnt_swap got %0d exp 4", pending_cnt); end
        vectors++; if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall got %b exp 1", hazard_stall); end
        for (int r = 2; r <= 5; r++) complete(5'(r));
        @(negedge clk); idle_inputs(); #1;
        vectors++; if (pending_cnt !== 3'd0) begin miscompares++; $display("FAIL drain_cnt got %0d exp 0", pending_cnt); end
        vectors++; if (sb_err !== 1'b0) begin miscompares++; $display("FAIL drain_err got %b exp 0", sb_err); end
    endtask

    task automatic test_simul();
        issue_long(5'd6);
        issue_long(5'd6); cmpl_valid = 1; cmpl_rd = 5'd6; #1;
        vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL simul_stall got %b exp 0", hazard_stall); end
        @(negedge clk); idle_inputs();
        rs_used = 2'b01; rs_addr = {5'd0, 5'd6}; #1;
        vectors++; if (pending_cnt !== 3'd1) begin miscompares++; $display("FAIL simul_cnt got %0d exp 1", pending_cnt); end
        vectors++; if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL simul_pending got %b exp 1", hazard_stall); end
        complete(5'd6);
        @(negedge clk); idle_inputs(); #1;
        vectors++; if (pending_cnt !== 3'd0) begin miscompares++; $display("FAIL simul_drain got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_sb_err_reset();
        complete(5'd12);
        @(negedge clk); idle_inputs(); #1;
        vectors++; if (sb_err !== 1'b1) begin miscompares++; $display("FAIL err_set got %b exp 1", sb_err); end
        vectors++; if (pending_cnt !== 3'd0) begin miscompares++; $display("FAIL err_cnt got %0d exp 0", pending_cnt); end
        issue_long(5'd3);
        @(negedge clk); idle_inputs(); #1;
        vectors++; if (sb_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b exp 1", sb_err); end
        vectors++; if (pending_cnt !== 3'd1) begin miscompares++; $display("FAIL pre_rst_cnt got %0d exp 1", pending_cnt); end
        #1 rst_n = 0; #1;
        vectors++; if (pending_cnt !== 3'd0) begin miscompares++; $display("FAIL async_rst_cnt got %0d exp 0", pending_cnt); end
        vectors++; if (sb_err !== 1'b0) begin miscompares++; $display("FAIL async_rst_err got %b exp 0", sb_err); end
        @(negedge clk); rst_n = 1;
        rs_used = 2'b01; rs_addr = {5'd0, 5'd3}; #1;
        vectors++; if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL rst_clears_pending got %b exp 0", hazard_stall); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_load_use();
        test_long_op();
        test_full_waw();
        test_simul();
        test_sb_err_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
